// File: rtl/tc_pl_cap_pkg.sv
// Shared types and helpers for the PL capture sequencer.
package tc_pl_cap_pkg;

   localparam int unsigned AW_DEF = 10;
   localparam int unsigned DW_DEF = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_WAIT,
      ST_POST,
      ST_DONE
   } cap_state_e;

   // Ring depth for a given address width.
   function automatic int unsigned cap_depth(input int unsigned aw);
      return 32'd1 << aw;
   endfunction

   function automatic int unsigned clamp_len(input int unsigned len,
                                             input int unsigned lo,
                                             input int unsigned hi);
      int unsigned r;
      r = (len < lo) ? lo : len;
      if (r > hi) r = hi;
      return r;
   endfunction

endpackage

// File: rtl/tc_pl_cap_seq_if.sv
// Sample-in / RAM-write bundle of the capture sequencer.
interface tc_pl_cap_seq_if
   import tc_pl_cap_pkg::*;
#(
   parameter int unsigned AW = AW_DEF,
   parameter int unsigned DW = DW_DEF
);
   logic          smp_vld;
   logic          evt_trig;
   logic [DW-1:0] smp_data;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;

   modport master (
      input  smp_vld, evt_trig, smp_data,
      output ram_we, ram_addr, ram_wdata
   );

   modport slave (
      output smp_vld, evt_trig, smp_data,
      input  ram_we, ram_addr, ram_wdata
   );
endinterface

// File: rtl/tc_pl_cap_wr_pipe.sv
// Registered RAM write stage with a wrapping ring address counter.
module tc_pl_cap_wr_pipe
   import tc_pl_cap_pkg::*;
#(
   parameter int unsigned AW = AW_DEF,
   parameter int unsigned DW = DW_DEF
) (
   input  logic          clk125,
   input  logic          rst,
   input  logic          addr_clr,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data,
   output logic [AW-1:0] cur_addr,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata
);

   logic [AW-1:0] cnt_q, cnt_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] data_q, data_d;

   always_comb begin
      cnt_d  = cnt_q;
      we_d   = 1'b0;
      addr_d = addr_q;
      data_d = data_q;
      if (addr_clr) begin
         cnt_d = '0;
      end else if (wr_en) begin
         we_d   = 1'b1;
         addr_d = cnt_q;
         data_d = wr_data;
         cnt_d  = cnt_q + AW'(1);
      end
   end

   always_ff @(posedge clk125) begin
      if (rst) begin
         cnt_q  <= '0;
         we_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         we_q   <= we_d;
         addr_q <= addr_d;
         data_q <= data_d;
      end
   end

   assign cur_addr  = cnt_q;
   assign ram_we    = we_q;
   assign ram_addr  = addr_q;
   assign ram_wdata = data_q;

endmodule

// File: rtl/tc_pl_cap_seq.sv
// Capture sequencer: pre-trigger / wait / post-trigger writes into a circular sample RAM.
//  state | meaning
//  IDLE  | waiting for a cap_trig rising edge
//  PRE   | filling the pre-trigger window (pl writes)
//  WAIT  | ring writes continue until a qualified evt_trig
//  POST  | post-trigger writes until ql samples incl. the trigger
//  DONE  | one-cycle completion, raises cap_cmpt
module tc_pl_cap_seq
   import tc_pl_cap_pkg::*;
#(
   parameter int unsigned AW = AW_DEF,
   parameter int unsigned DW = DW_DEF
) (
   input  logic                clk125,
   input  logic                rst,
   input  logic                cap_trig,
   input  logic                cap_abort,
   input  logic [AW-1:0]       pre_len,
   input  logic [AW-1:0]       post_len,
   tc_pl_cap_seq_if.master     bus,
   output logic [AW-1:0]       trig_addr,
   output logic                cap_cing,
   output logic                cap_cmpt
);

   localparam int unsigned DEPTH = cap_depth(AW);
   localparam int unsigned CW    = AW + 1;

   cap_state_e    state_q, state_d;
   logic          cap_trig_dly_q, cap_trig_dly_d;
   logic [CW-1:0] pl_q, pl_d;
   logic [CW-1:0] ql_q, ql_d;
   logic [CW-1:0] pre_cnt_q, pre_cnt_d;
   logic [CW-1:0] post_cnt_q, post_cnt_d;
   logic [AW-1:0] trig_addr_q, trig_addr_d;
   logic          cap_cing_q, cap_cing_d;
   logic          cap_cmpt_q, cap_cmpt_d;

   logic          trig_rise;
   logic          addr_clr;
   logic          wr_en;
   logic [AW-1:0] cur_addr;
   logic [CW-1:0] pl_new, ql_new;

   always_comb begin
      pl_new = CW'(clamp_len(32'(pre_len), 32'd0, DEPTH - 32'd1));
      ql_new = CW'(clamp_len(32'(post_len), 32'd1, DEPTH - 32'(pl_new)));
   end

   always_comb begin
      state_d        = state_q;
      cap_trig_dly_d = cap_trig;
      pl_d           = pl_q;
      ql_d           = ql_q;
      pre_cnt_d      = pre_cnt_q;
      post_cnt_d     = post_cnt_q;
      trig_addr_d    = trig_addr_q;
      addr_clr       = 1'b0;
      wr_en          = 1'b0;
      trig_rise      = cap_trig & ~cap_trig_dly_q;

      // Abort wins over everything, including a start edge seen in IDLE.
      if (cap_abort) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (trig_rise) begin
                  addr_clr  = 1'b1;
                  pl_d      = pl_new;
                  ql_d      = ql_new;
                  pre_cnt_d = '0;
                  state_d   = (pl_new == '0) ? ST_WAIT : ST_PRE;
               end
            end
            ST_PRE: begin
               if (bus.smp_vld) begin
                  wr_en     = 1'b1;
                  pre_cnt_d = pre_cnt_q + CW'(1);
                  if (pre_cnt_q + CW'(1) == pl_q) state_d = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (bus.smp_vld) begin
                  wr_en = 1'b1;
                  if (bus.evt_trig) begin
                     trig_addr_d = cur_addr;
                     post_cnt_d  = CW'(1);
                     state_d     = (ql_q == CW'(1)) ? ST_DONE : ST_POST;
                  end
               end
            end
            ST_POST: begin
               if (bus.smp_vld) begin
                  wr_en      = 1'b1;
                  post_cnt_d = post_cnt_q + CW'(1);
                  if (post_cnt_q + CW'(1) == ql_q) state_d = ST_DONE;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      cap_cing_d = (state_d == ST_PRE) || (state_d == ST_WAIT) || (state_d == ST_POST);
      cap_cmpt_d = (state_q == ST_DONE) && !cap_abort;
   end

   always_ff @(posedge clk125) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         cap_trig_dly_q <= 1'b0;
         pl_q           <= '0;
         ql_q           <= '0;
         pre_cnt_q      <= '0;
         post_cnt_q     <= '0;
         trig_addr_q    <= '0;
         cap_cing_q     <= 1'b0;
         cap_cmpt_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         cap_trig_dly_q <= cap_trig_dly_d;
         pl_q           <= pl_d;
         ql_q           <= ql_d;
         pre_cnt_q      <= pre_cnt_d;
         post_cnt_q     <= post_cnt_d;
         trig_addr_q    <= trig_addr_d;
         cap_cing_q     <= cap_cing_d;
         cap_cmpt_q     <= cap_cmpt_d;
      end
   end

   tc_pl_cap_wr_pipe #(
      .AW (AW),
      .DW (DW)
   ) u_wr_pipe (
      .clk125    (clk125),
      .rst       (rst),
      .addr_clr  (addr_clr),
      .wr_en     (wr_en),
      .wr_data   (bus.smp_data),
      .cur_addr  (cur_addr),
      .ram_we    (bus.ram_we),
      .ram_addr  (bus.ram_addr),
      .ram_wdata (bus.ram_wdata)
   );

   assign trig_addr = trig_addr_q;
   assign cap_cing  = cap_cing_q;
   assign cap_cmpt  = cap_cmpt_q;

endmodule
